// File: rtl/dot_product_pkg.sv
// Shared constants and FSM encoding for the dot-product feeder.
package dot_product_pkg;

    localparam int ELEM_W        = 4;
    localparam int N_LANE        = 4;
    localparam int RES_W         = 10;
    localparam int LIDX_W        = $clog2(N_LANE);
    localparam int CORE_LAT_COMB = 2;
    localparam int CORE_LAT_PIPE = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        RESULT  = 2'd2
    } state_e;

endpackage

// File: rtl/dot_product_feeder.sv
// Serial-to-parallel operand feeder for the 4-lane dot-product core: packs x/y
// pairs into the lanes, waits CORE_LAT edges, and returns the captured result.
module dot_product_feeder
    import dot_product_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_COMB,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ELEM_W-1:0] i_x,
    input  logic [ELEM_W-1:0] i_y,
    input  logic              i_last,
    output logic [ELEM_W-1:0] o_a,
    output logic [ELEM_W-1:0] o_b,
    output logic [ELEM_W-1:0] o_c,
    output logic [ELEM_W-1:0] o_d,
    output logic [ELEM_W-1:0] o_e,
    output logic [ELEM_W-1:0] o_f,
    output logic [ELEM_W-1:0] o_g,
    output logic [ELEM_W-1:0] o_h,
    input  logic [RES_W-1:0]  i_dp_out,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [RES_W-1:0]  o_res,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_vec_cnt
);

    localparam int WCNT_W = $clog2(CORE_LAT + 1);

    state_e              state_q, state_d;
    logic [LIDX_W-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ELEM_W-1:0]   x_q [N_LANE];
    logic [ELEM_W-1:0]   x_d [N_LANE];
    logic [ELEM_W-1:0]   y_q [N_LANE];
    logic [ELEM_W-1:0]   y_d [N_LANE];
    logic [RES_W-1:0]    res_q, res_d;
    logic                res_valid_q, res_valid_d;
    logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic                ready_en_q;
    logic                accept_s;

    // ready_en_q keeps o_ready low until the first edge after reset release
    assign o_ready  = (state_q == COLLECT) && ready_en_q;
    assign o_busy   = (state_q != COLLECT);
    assign accept_s = i_valid && o_ready;

    // Next-state, lane packing, wait counting and result capture
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        vec_cnt_d   = vec_cnt_q;
        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    x_d[idx_q] = i_x;
                    y_d[idx_q] = i_y;
                    if ((idx_q == LIDX_W'(N_LANE - 1)) || i_last) begin
                        for (int i = 0; i < N_LANE; i++) begin
                            if (LIDX_W'(i) > idx_q) begin
                                x_d[i] = {ELEM_W{1'b0}};
                                y_d[i] = {ELEM_W{1'b0}};
                            end else begin
                                x_d[i] = x_d[i];
                                y_d[i] = y_d[i];
                            end
                        end
                        idx_d   = {LIDX_W{1'b0}};
                        wcnt_d  = {WCNT_W{1'b0}};
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + LIDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            WAIT: begin
                // Lanes have been stable since entry; the core output is valid now
                if (wcnt_q == WCNT_W'(CORE_LAT)) begin
                    res_d       = i_dp_out;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            RESULT: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    vec_cnt_d   = vec_cnt_q + CNT_W'(1);
                    state_d     = COLLECT;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= COLLECT;
            idx_q       <= {LIDX_W{1'b0}};
            wcnt_q      <= {WCNT_W{1'b0}};
            res_q       <= {RES_W{1'b0}};
            res_valid_q <= 1'b0;
            vec_cnt_q   <= {CNT_W{1'b0}};
            ready_en_q  <= 1'b0;
            for (int i = 0; i < N_LANE; i++) begin
                x_q[i] <= {ELEM_W{1'b0}};
                y_q[i] <= {ELEM_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            vec_cnt_q   <= vec_cnt_d;
            ready_en_q  <= 1'b1;
            for (int i = 0; i < N_LANE; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign o_a         = x_q[0];
    assign o_b         = x_q[1];
    assign o_c         = x_q[2];
    assign o_d         = x_q[3];
    assign o_e         = y_q[0];
    assign o_f         = y_q[1];
    assign o_g         = y_q[2];
    assign o_h         = y_q[3];
    assign o_res       = res_q;
    assign o_res_valid = res_valid_q;
    assign o_vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench: two feeders (CORE_LAT=2 and 4) each driving a behavioural core model.
module tb_dot_product_feeder;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sel;
    logic              i_valid, i_last, i_res_ready;
    logic [3:0]        i_x, i_y;
    logic              rdy_c, rdy_p, rv_c, rv_p, busy_c, busy_p;
    logic [7:0][3:0]   lc, lp;
    logic [9:0]        res_c, res_p, dp_c, dp_p;
    logic [15:0]       cnt_c, cnt_p;
    logic [9:0]        pc0, pc1, pp0, pp1, pp2, pp3;

    int total = 0;
    int bad   = 0;
    int exp_cnt [2];

    always #5 clk = ~clk;

    dot_product_feeder #(.CORE_LAT(2), .CNT_W(16)) u_c (
        .i_clk(clk), .i_rstn(rst_n), .i_valid(i_valid & ~sel), .o_ready(rdy_c),
        .i_x(i_x), .i_y(i_y), .i_last(i_last),
        .o_a(lc[0]), .o_b(lc[1]), .o_c(lc[2]), .o_d(lc[3]),
        .o_e(lc[4]), .o_f(lc[5]), .o_g(lc[6]), .o_h(lc[7]),
        .i_dp_out(dp_c), .o_res_valid(rv_c), .i_res_ready(i_res_ready & ~sel),
        .o_res(res_c), .o_busy(busy_c), .o_vec_cnt(cnt_c));

    dot_product_feeder #(.CORE_LAT(4), .CNT_W(16)) u_p (
        .i_clk(clk), .i_rstn(rst_n), .i_valid(i_valid & sel), .o_ready(rdy_p),
        .i_x(i_x), .i_y(i_y), .i_last(i_last),
        .o_a(lp[0]), .o_b(lp[1]), .o_c(lp[2]), .o_d(lp[3]),
        .o_e(lp[4]), .o_f(lp[5]), .o_g(lp[6]), .o_h(lp[7]),
        .i_dp_out(dp_p), .o_res_valid(rv_p), .i_res_ready(i_res_ready & sel),
        .o_res(res_p), .o_busy(busy_p), .o_vec_cnt(cnt_p));

    function automatic logic [9:0] core_dp(input logic [7:0][3:0] l);
        logic [9:0] s = 10'd0;
        for (int i = 0; i < 4; i++) s = s + 10'(l[i]) * 10'(l[i+4]);
        return s;
    endfunction

    // Core models: result appears CORE_LAT edges after the lanes settle
    always @(posedge clk) begin
        pc0 <= core_dp(lc); pc1 <= pc0;
        pp0 <= core_dp(lp); pp1 <= pp0; pp2 <= pp1; pp3 <= pp2;
    end
    assign dp_c = pc1;
    assign dp_p = pp3;

    logic             m_ready, m_rv, m_busy;
    logic [9:0]       m_res;
    logic [15:0]      m_cnt;
    logic [7:0][3:0]  m_l;
    assign m_ready = sel ? rdy_p  : rdy_c;
    assign m_rv    = sel ? rv_p   : rv_c;
    assign m_busy  = sel ? busy_p : busy_c;
    assign m_res   = sel ? res_p  : res_c;
    assign m_cnt   = sel ? cnt_p  : cnt_c;
    assign m_l     = sel ? lp     : lc;

    typedef struct {
        logic [3:0][3:0] xs;
        logic [3:0][3:0] ys;
        int n, gap, s, hold, early, exp_res;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][3:0] mk(input int a, input int b, input int c, input int d);
        logic [3:0][3:0] v;
        v[0] = 4'(a); v[1] = 4'(b); v[2] = 4'(c); v[3] = 4'(d);
        return v;
    endfunction

    function automatic int ref_dot(input logic [3:0][3:0] xs, input logic [3:0][3:0] ys, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(xs[i]) * int'(ys[i]);
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic put_pair(input logic [3:0] x, input logic [3:0] y, input logic last);
        int t = 0;
        i_valid = 1'b1; i_x = x; i_y = y; i_last = last;
        while (!m_ready && t < 50) begin @(negedge clk); t++; end
        if (!m_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int k = 0;
        sel = v.s[0];
        @(negedge clk);
        for (int j = 0; j < v.n; j++) begin
            // i_last without i_valid must not close the vector
            repeat (v.gap) begin i_last = 1'b1; @(negedge clk); end
            put_pair(v.xs[j], v.ys[j], j == v.n - 1);
        end
        for (int i = 0; i < 4; i++) begin
            chk({nm, "_lane_x"}, int'(m_l[i]),   (i < v.n) ? int'(v.xs[i]) : 0);
            chk({nm, "_lane_y"}, int'(m_l[i+4]), (i < v.n) ? int'(v.ys[i]) : 0);
        end
        chk({nm, "_busy"}, int'(m_busy), 1);
        chk({nm, "_ready_wait"}, int'(m_ready), 0);
        i_res_ready = v.early[0];
        while (!m_rv && k < 40) begin @(negedge clk); k++; end
        chk({nm, "_latency"}, k, (v.s != 0 ? 4 : 2) + 1);
        chk({nm, "_res"}, int'(m_res), v.exp_res);
        if (v.hold > 0) begin
            i_valid = 1'b1; i_x = 4'd9; i_y = 4'd9;
            repeat (v.hold) begin
                @(negedge clk);
                chk({nm, "_hold_res"}, int'(m_res), v.exp_res);
                chk({nm, "_hold_rv"}, int'(m_rv), 1);
                chk({nm, "_hold_ready"}, int'(m_ready), 0);
                chk({nm, "_hold_lane"}, int'(m_l[0]), int'(v.xs[0]));
            end
            i_valid = 1'b0;
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        exp_cnt[v.s] = (exp_cnt[v.s] + 1) % 65536;
        chk({nm, "_rv_clear"}, int'(m_rv), 0);
        chk({nm, "_ready_back"}, int'(m_ready), 1);
        chk({nm, "_vec_cnt"}, int'(m_cnt), exp_cnt[v.s]);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_lanes_c"}, int'(lc), 0);
        chk({nm, "_lanes_p"}, int'(lp), 0);
        chk({nm, "_res"}, int'(res_c) + int'(res_p), 0);
        chk({nm, "_rv"}, int'(rv_c) + int'(rv_p), 0);
        chk({nm, "_busy"}, int'(busy_c) + int'(busy_p), 0);
        chk({nm, "_cnt"}, int'(cnt_c) + int'(cnt_p), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        rst_n = 1'b0; sel = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        i_res_ready = 1'b0; i_x = 4'd0; i_y = 4'd0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;

        tbl[0] = '{mk(1,2,3,4),     mk(5,6,7,8),     4, 0, 0, 0, 0, 70};
        tbl[1] = '{mk(15,15,0,0),   mk(15,15,0,0),   2, 0, 0, 0, 0, 450};
        tbl[2] = '{mk(15,15,15,15), mk(15,15,15,15), 4, 0, 0, 0, 0, 900};
        tbl[3] = '{mk(1,2,3,4),     mk(5,6,7,8),     4, 0, 0, 5, 0, 70};
        tbl[4] = '{mk(1,1,1,1),     mk(1,1,1,1),     4, 0, 0, 0, 0, 4};
        tbl[5] = '{mk(1,2,3,4),     mk(5,6,7,8),     4, 1, 1, 0, 0, 70};
        tbl[6] = '{mk(3,9,2,0),     mk(7,1,11,0),    3, 0, 0, 0, 1, 52};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(rdy_c) + int'(rdy_p), 2);

        foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Reset while the CORE_LAT=2 feeder is waiting on the core
        sel = 1'b0;
        @(negedge clk);
        put_pair(4'd2, 4'd2, 1'b0);
        put_pair(4'd3, 4'd3, 1'b1);
        @(negedge clk);
        chk("midreset_in_wait", int'(busy_c), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", int'(rdy_c), 1);
        run_vec("post_reset", '{mk(1,1,1,1), mk(2,2,2,2), 4, 0, 0, 0, 0, 8});

        for (int r = 0; r < 16; r++) begin
            rv.n     = $urandom_range(1, 4);
            rv.gap   = $urandom_range(0, 2);
            rv.s     = $urandom_range(0, 1);
            rv.hold  = $urandom_range(0, 3);
            rv.early = (rv.hold == 0) ? $urandom_range(0, 1) : 0;
            for (int i = 0; i < 4; i++) begin
                rv.xs[i] = 4'($urandom_range(0, 15));
                rv.ys[i] = 4'($urandom_range(0, 15));
            end
            rv.exp_res = ref_dot(rv.xs, rv.ys, rv.n);
            run_vec($sformatf("rnd%0d", r), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
